ucdp_sync_hs_tx: RTL
====================

Name: ucdp_sync_hs_tx

Overview:
- Source-side controller for a 4-phase req/ack handshake crossing into an unrelated clock domain.
- Accepts transfer requests with data from the local domain and drives a level `req_o` with stable `data_o`.
- Synchronizes the remote `ack_i` through an internal 2-flop synchronizer and sequences the protocol.
- Holds one pending request so back-to-back starts are not lost. Used by the remote-domain `ucdp_sync_hs_rx` counterpart and by register-file CDC bridges.

Parameters:
- width_p, 8: data width in bits, 1..64.
- rstval_p, 1'b0: reset value of `data_o` and of the pending buffer data (replicated to width_p).

Ports:
- main_clk_i  input  1  local clock.
- main_rst_an_i  input  1  asynchronous reset, active-low.
- dft_mode_scan_shift_i  input  1  scan shift phase; forwarded to the ack synchronizer flops.
- start_i  input  1  single-cycle transfer request.
- data_i  input  width_p  data captured with start_i.
- req_o  output  1  handshake request level to the remote domain.
- data_o  output  width_p  transfer data; stable while req_o=1 and until ack is observed low.
- ack_i  input  1  asynchronous acknowledge from the remote domain.
- busy_o  output  1  high while a transfer is in flight (state != IDLE).
- pend_o  output  1  pending buffer occupied.
- done_o  output  1  one-cycle pulse when a transfer completes (ack observed low).
- ovf_o  output  1  one-cycle pulse when start_i is dropped.

Behaviour:
- Reset values: req_o=0, data_o=rstval_p, busy_o=0, pend_o=0, done_o=0, ovf_o=0, ack_s=0, state=IDLE.
- Ack synchronizer:
  - 2 flops reset to 0; ack_s = second stage.
  - Latency is 2 main_clk_i edges from an ack_i change to ack_s.
- FSM states:
  - IDLE: req_o=0. On start_i: data_o<=data_i; next state REQ. req_o=1 from the following cycle (1-cycle start-to-req latency).
  - REQ: req_o=1. When ack_s=1: next state REL.
  - REL: req_o=0 (registered; drops the cycle after ack_s seen high). When ack_s=0: done_o=1 for one cycle, then:
    - pending valid: data_o<=pending data; pend clears; next state REQ.
    - else start_i asserted this cycle: data_o<=data_i; next state REQ (bypass).
    - else: next state IDLE.
- req_o, done_o and ovf_o are registered outputs.
- Pending buffer:
  - start_i while state != IDLE and not the REL-completion cycle: store data_i if pend empty, pend_o=1.
  - If pend is already full: drop data_i and pulse ovf_o; stored pending data is unchanged.
- start_i in IDLE always starts immediately; the pending buffer is never used from IDLE.
- REL-completion cycle with pend full and start_i=1: pending data is sent first, data_i is stored in the freed pend slot, no overflow.
- data_o changes only when entering REQ; never while in REQ or REL.
- ack_i already high at IDLE->REQ (protocol violation by the peer): REQ exits when ack_s=1 as normal; no special handling.
- Reset mid-transfer: all state clears asynchronously; the remote side must be reset together with this block.
- Throughput: at least 2+2+2 cycles per transfer plus remote latency.

Optional Feature:
- Macro UCDP_SYNC_HS_TX_TIMEOUT_EN.
- When defined:
  - Adds parameter timeout_p (default 16'd1023) and output timeout_o (1 bit, reset 0).
  - A 16-bit counter clears on every state change and increments in REQ/REL, saturating.
  - When it reaches timeout_p: timeout_o pulses one cycle, FSM forces req_o=0, pend is cleared, and the next state is IDLE.
  - No done_o is produced for an aborted transfer.
- When undefined: no counter, no timeout_o port; the FSM waits indefinitely.

Test Plan:
- Single transfer:
  - Stimulus: start_i with data_i=8'hA5; remote acks 3 cycles after req_o rises and drops ack 3 cycles after req_o falls.
  - Response: req_o=1 one cycle after start; data_o=8'hA5 throughout; one done_o pulse; then IDLE, busy_o=0.
- Back-to-back:
  - Stimulus: start 8'h11, then start 8'h22 two cycles later.
  - Response: pend_o=1; after done_o for 8'h11, data_o=8'h22 and req_o rises the next cycle; two done_o pulses total; ovf_o stays 0.
- Overflow:
  - Stimulus: start 8'h01, 8'h02, 8'h03 while the first is in REQ.
  - Response: ovf_o pulses on the third start; transfers complete for 8'h01 and 8'h02 only.
- Bypass:
  - Stimulus: start_i=1 with 8'h77 exactly in the REL-completion cycle, pend empty.
  - Response: done_o=1 and state goes directly to REQ with data_o=8'h77; no IDLE cycle.
- Reset mid-operation:
  - Stimulus: assert main_rst_an_i=0 during REQ with pend full.
  - Response: immediately req_o=0, pend_o=0, data_o=rstval_p; after release, the block is idle and ack_s=0 two cycles after ack_i=0.
- Timeout (macro defined, timeout_p=20):
  - Stimulus: never ack.
  - Response: timeout_o pulses after 20 cycles in REQ; req_o=0 the next cycle; busy_o=0; no done_o.

Source files
------------

// File: rtl/ucdp_sync_hs_tx.sv
// rtl/ucdp_sync_hs_tx.sv - source side of a 4-phase req/ack CDC handshake with one pending slot
// Optional: define UCDP_SYNC_HS_TX_TIMEOUT_EN for the REQ/REL abort timer (timeout_p, timeout_o).
module ucdp_sync_hs_tx #(
    parameter int unsigned width_p  = 8,
    parameter logic        rstval_p = 1'b0
`ifdef UCDP_SYNC_HS_TX_TIMEOUT_EN
    ,
    parameter logic [15:0] timeout_p = 16'd1023
`endif
) (
    input  logic               main_clk_i,
    input  logic               main_rst_an_i,
    input  logic               dft_mode_scan_shift_i,
    input  logic               start_i,
    input  logic [width_p-1:0] data_i,
    output logic               req_o,
    output logic [width_p-1:0] data_o,
    input  logic               ack_i,
    output logic               busy_o,
    output logic               pend_o,
    output logic               done_o,
    output logic               ovf_o
`ifdef UCDP_SYNC_HS_TX_TIMEOUT_EN
    ,
    output logic               timeout_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam logic [width_p-1:0] DataRst = {width_p{rstval_p}};

    state_t             state_q;
    state_t             state_d;
    logic               ack_meta_q;
    logic               ack_s;
    logic               req_q;
    logic               req_d;
    logic               done_q;
    logic               done_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;
    logic               pend_vld_q;
    logic               pend_vld_d;
    logic [width_p-1:0] pend_data_q;
    logic [width_p-1:0] pend_data_d;
    logic               cpl;
    logic               abort;

    // Two-stage ack synchronizer; frozen during scan shift so shifting never disturbs the capture path.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            ack_meta_q <= 1'b0;
            ack_s      <= 1'b0;
        end else if (!dft_mode_scan_shift_i) begin
            ack_meta_q <= ack_i;
            ack_s      <= ack_meta_q;
        end
    end

    // The completion cycle: release phase has seen the remote ack return low.
    assign cpl = (state_q == ST_REL) && !ack_s;

`ifdef UCDP_SYNC_HS_TX_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        timeout_q;

    // Cycles spent in the current state; restarts on every state change and saturates.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            tmo_cnt_q <= 16'd0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= 16'd0;
        end else if ((state_q != ST_IDLE) && (tmo_cnt_q != 16'hFFFF)) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // Abort a transfer whose peer stopped answering.
    assign abort = (state_q != ST_IDLE) && (tmo_cnt_q == timeout_p);

    // One-cycle abort indication.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign abort = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            data_q      <= DataRst;
            pend_vld_q  <= 1'b0;
            pend_data_q <= DataRst;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            data_q      <= data_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Protocol sequencing: request, wait for ack high, release, wait for ack low.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_REQ;
                ST_REQ:  if (ack_s) state_d = ST_REL;
                ST_REL: begin
                    if (!ack_s) begin
                        state_d = (pend_vld_q || start_i) ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of data, pending slot and pulse outputs; data only moves when entering REQ.
    always_comb begin
        req_d       = (state_d == ST_REQ);
        done_d      = 1'b0;
        ovf_d       = 1'b0;
        data_d      = data_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        if (abort) begin
            pend_vld_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                data_d = data_i;
            end
        end else if (cpl) begin
            done_d = 1'b1;
            if (pend_vld_q) begin
                // Older pending word goes first; a concurrent start refills the freed slot.
                data_d     = pend_data_q;
                pend_vld_d = start_i;
                if (start_i) begin
                    pend_data_d = data_i;
                end
            end else if (start_i) begin
                data_d = data_i;
            end
        end else if (start_i) begin
            if (!pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_data_d = data_i;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign req_o  = req_q;
    assign data_o = data_q;
    assign done_o = done_q;
    assign ovf_o  = ovf_q;
    assign pend_o = pend_vld_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule
